// File: rtl/sargantana_icache_ifill_ctrl.sv
// I-cache line-fill controller: one miss at a time, line-aligned fill request,
// beat assembly into a line buffer, single-cycle way write unless killed or snooped.
//   state   | meaning
//   S_IDLE  | ready for a miss
//   S_REQ   | fill request held until the fabric acks
//   S_WAIT  | collecting response beats into the line buffer
//   S_DRAIN | discarding remaining beats after a kill
//   S_WRITE | one-cycle line write (suppressed when poisoned)
module sargantana_icache_ifill_ctrl #(
  parameter int LINE_WIDTH   = 256,
  parameter int BEAT_WIDTH   = 64,
  parameter int N_WAY        = 4,
  parameter int PADDR_SIZE   = 40,
  parameter int OFFSET_WIDTH = 5,
  parameter int IDX_WIDTH    = 7,
  parameter int TAG_WIDTH    = 28,
  localparam int NBEATS = LINE_WIDTH / BEAT_WIDTH,
  localparam int WAY_W  = (N_WAY > 1) ? $clog2(N_WAY) : 1,
  localparam int BIDX_W = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    miss_valid_i,
  output logic                    miss_ready_o,
  input  logic [PADDR_SIZE-1:0]   miss_paddr_i,
  input  logic [WAY_W-1:0]        miss_way_i,
  input  logic                    kill_i,
  output logic                    ifill_req_valid_o,
  output logic [WAY_W-1:0]        ifill_req_way_o,
  output logic [PADDR_SIZE-1:0]   ifill_req_paddr_o,
  input  logic                    ifill_ack_i,
  input  logic                    ifill_resp_valid_i,
  input  logic [BIDX_W-1:0]       ifill_resp_beat_i,
  input  logic [BEAT_WIDTH-1:0]   ifill_resp_data_i,
  input  logic                    inv_valid_i,
  input  logic [11:0]             inv_paddr_i,
  output logic                    line_we_o,
  output logic [WAY_W-1:0]        line_way_o,
  output logic [IDX_WIDTH-1:0]    line_idx_o,
  output logic [TAG_WIDTH-1:0]    line_tag_o,
  output logic [LINE_WIDTH-1:0]   line_data_o,
  output logic                    busy_o,
  output logic [15:0]             fill_cnt_o
);

  localparam int CNT_W   = $clog2(NBEATS) + 1;
  localparam int LADDR_W = PADDR_SIZE - OFFSET_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_WRITE} state_e;

  state_e                 state_q, state_d;
  logic [LADDR_W-1:0]     laddr_q, laddr_d;
  logic [WAY_W-1:0]       way_q, way_d;
  logic [LINE_WIDTH-1:0]  line_q, line_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   poison_q, poison_d;
  logic [15:0]            fill_cnt_q, fill_cnt_d;
  logic [BIDX_W-1:0]      beat_idx;
  logic                   last_beat;
  logic                   inv_hit;
  logic                   unused_offsets;

  assign unused_offsets = ^{miss_paddr_i[OFFSET_WIDTH-1:0], inv_paddr_i[OFFSET_WIDTH-1:0]};

  // With a single beat the index input carries no information.
  assign beat_idx  = (NBEATS > 1) ? ifill_resp_beat_i : '0;
  assign last_beat = ifill_resp_valid_i && (cnt_q == CNT_W'(NBEATS - 1));
  assign inv_hit   = inv_valid_i && (inv_paddr_i[11:OFFSET_WIDTH] == laddr_q[IDX_WIDTH-1:0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      laddr_q    <= '0;
      way_q      <= '0;
      line_q     <= '0;
      cnt_q      <= '0;
      poison_q   <= 1'b0;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      laddr_q    <= laddr_d;
      way_q      <= way_d;
      line_q     <= line_d;
      cnt_q      <= cnt_d;
      poison_q   <= poison_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    laddr_d    = laddr_q;
    way_d      = way_q;
    line_d     = line_q;
    cnt_d      = cnt_q;
    poison_d   = poison_q;
    fill_cnt_d = fill_cnt_q;
    line_we_o  = 1'b0;

    // A snoop in WRITE is ordered after the write by the cache, so it is not sampled there.
    if ((state_q == S_REQ || state_q == S_WAIT || state_q == S_DRAIN) && inv_hit) begin
      poison_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (miss_valid_i) begin
          laddr_d  = miss_paddr_i[PADDR_SIZE-1:OFFSET_WIDTH];
          way_d    = miss_way_i;
          poison_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (ifill_ack_i) begin
          state_d = kill_i ? S_DRAIN : S_WAIT;
        end else if (kill_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (ifill_resp_valid_i) begin
          line_d[beat_idx*BEAT_WIDTH +: BEAT_WIDTH] = ifill_resp_data_i;
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (kill_i) begin
          state_d = last_beat ? S_IDLE : S_DRAIN;
        end else if (last_beat) begin
          state_d = S_WRITE;
        end
      end
      S_DRAIN: begin
        if (ifill_resp_valid_i) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (last_beat) begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        line_we_o = !poison_q;
        if (!poison_q && fill_cnt_q != 16'hFFFF) begin
          fill_cnt_d = fill_cnt_q + 16'd1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign miss_ready_o      = (state_q == S_IDLE);
  assign busy_o            = (state_q != S_IDLE);
  assign ifill_req_valid_o = (state_q == S_REQ);
  assign ifill_req_way_o   = way_q;
  assign ifill_req_paddr_o = {laddr_q, {OFFSET_WIDTH{1'b0}}};
  assign line_way_o        = way_q;
  assign line_idx_o        = laddr_q[IDX_WIDTH-1:0];
  assign line_tag_o        = laddr_q[LADDR_W-1:IDX_WIDTH];
  assign line_data_o       = line_q;
  assign fill_cnt_o        = fill_cnt_q;

endmodule

// File: tb/tb_sargantana_icache_ifill_ctrl.sv
// Directed + randomized bench for the I-cache fill controller, with a transaction-level
// expectation model; also exercises a 512/128 and a single-beat configuration.
module tb_sargantana_icache_ifill_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default configuration: 256-bit line, 4 beats of 64
  logic         miss_valid, miss_ready, kill, req_valid, ack, resp_valid, inv_valid;
  logic         line_we, busy;
  logic [39:0]  miss_paddr, req_paddr;
  logic [1:0]   miss_way, req_way, line_way, resp_beat;
  logic [63:0]  resp_data;
  logic [11:0]  inv_paddr;
  logic [6:0]   line_idx;
  logic [27:0]  line_tag;
  logic [255:0] line_data;
  logic [15:0]  fill_cnt;

  sargantana_icache_ifill_ctrl u_dut (
    .clk_i(clk), .rst_i(rst),
    .miss_valid_i(miss_valid), .miss_ready_o(miss_ready), .miss_paddr_i(miss_paddr),
    .miss_way_i(miss_way), .kill_i(kill),
    .ifill_req_valid_o(req_valid), .ifill_req_way_o(req_way), .ifill_req_paddr_o(req_paddr),
    .ifill_ack_i(ack), .ifill_resp_valid_i(resp_valid), .ifill_resp_beat_i(resp_beat),
    .ifill_resp_data_i(resp_data), .inv_valid_i(inv_valid), .inv_paddr_i(inv_paddr),
    .line_we_o(line_we), .line_way_o(line_way), .line_idx_o(line_idx), .line_tag_o(line_tag),
    .line_data_o(line_data), .busy_o(busy), .fill_cnt_o(fill_cnt)
  );

  // wide configuration: 512-bit line, 4 beats of 128
  logic         w_miss_valid, w_miss_ready, w_kill, w_req_valid, w_ack, w_resp_valid, w_inv_valid;
  logic         w_line_we, w_busy;
  logic [39:0]  w_miss_paddr, w_req_paddr;
  logic [1:0]   w_miss_way, w_req_way, w_line_way, w_resp_beat;
  logic [127:0] w_resp_data;
  logic [11:0]  w_inv_paddr;
  logic [6:0]   w_line_idx;
  logic [27:0]  w_line_tag;
  logic [511:0] w_line_data;
  logic [15:0]  w_fill_cnt;

  sargantana_icache_ifill_ctrl #(.LINE_WIDTH(512), .BEAT_WIDTH(128)) u_wide (
    .clk_i(clk), .rst_i(rst),
    .miss_valid_i(w_miss_valid), .miss_ready_o(w_miss_ready), .miss_paddr_i(w_miss_paddr),
    .miss_way_i(w_miss_way), .kill_i(w_kill),
    .ifill_req_valid_o(w_req_valid), .ifill_req_way_o(w_req_way), .ifill_req_paddr_o(w_req_paddr),
    .ifill_ack_i(w_ack), .ifill_resp_valid_i(w_resp_valid), .ifill_resp_beat_i(w_resp_beat),
    .ifill_resp_data_i(w_resp_data), .inv_valid_i(w_inv_valid), .inv_paddr_i(w_inv_paddr),
    .line_we_o(w_line_we), .line_way_o(w_line_way), .line_idx_o(w_line_idx), .line_tag_o(w_line_tag),
    .line_data_o(w_line_data), .busy_o(w_busy), .fill_cnt_o(w_fill_cnt)
  );

  // single-beat configuration
  logic         o_miss_valid, o_miss_ready, o_kill, o_req_valid, o_ack, o_resp_valid, o_inv_valid;
  logic         o_line_we, o_busy;
  logic [39:0]  o_miss_paddr, o_req_paddr;
  logic [1:0]   o_miss_way, o_req_way, o_line_way;
  logic [0:0]   o_resp_beat;
  logic [63:0]  o_resp_data, o_line_data;
  logic [11:0]  o_inv_paddr;
  logic [6:0]   o_line_idx;
  logic [27:0]  o_line_tag;
  logic [15:0]  o_fill_cnt;

  sargantana_icache_ifill_ctrl #(.LINE_WIDTH(64), .BEAT_WIDTH(64)) u_one (
    .clk_i(clk), .rst_i(rst),
    .miss_valid_i(o_miss_valid), .miss_ready_o(o_miss_ready), .miss_paddr_i(o_miss_paddr),
    .miss_way_i(o_miss_way), .kill_i(o_kill),
    .ifill_req_valid_o(o_req_valid), .ifill_req_way_o(o_req_way), .ifill_req_paddr_o(o_req_paddr),
    .ifill_ack_i(o_ack), .ifill_resp_valid_i(o_resp_valid), .ifill_resp_beat_i(o_resp_beat),
    .ifill_resp_data_i(o_resp_data), .inv_valid_i(o_inv_valid), .inv_paddr_i(o_inv_paddr),
    .line_we_o(o_line_we), .line_way_o(o_line_way), .line_idx_o(o_line_idx), .line_tag_o(o_line_tag),
    .line_data_o(o_line_data), .busy_o(o_busy), .fill_cnt_o(o_fill_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_fills = 0;    // fill counter expectation (cleared by reset)
  int exp_writes = 0;   // total write strobes expected over the whole run
  int we_seen = 0;

  always @(negedge clk) if (line_we === 1'b1) we_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_inputs();
    miss_valid = 0; miss_paddr = '0; miss_way = '0; kill = 0; ack = 0;
    resp_valid = 0; resp_beat = '0; resp_data = '0; inv_valid = 0; inv_paddr = '0;
    w_miss_valid = 0; w_miss_paddr = '0; w_miss_way = '0; w_kill = 0; w_ack = 0;
    w_resp_valid = 0; w_resp_beat = '0; w_resp_data = '0; w_inv_valid = 0; w_inv_paddr = '0;
    o_miss_valid = 0; o_miss_paddr = '0; o_miss_way = '0; o_kill = 0; o_ack = 0;
    o_resp_valid = 0; o_resp_beat = '0; o_resp_data = '0; o_inv_valid = 0; o_inv_paddr = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, miss_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_reqv"}, req_valid, 1'b0);
    chk({tag, "_reqpa"}, req_paddr, 40'h0);
    chk({tag, "_we"}, line_we, 1'b0);
    chk({tag, "_data"}, line_data, 256'h0);
    chk({tag, "_idx"}, line_idx, 7'h0);
    chk({tag, "_cnt"}, fill_cnt, 16'h0);
  endtask

  // One miss on the default DUT.
  //   order_mode: 0 in order, 1 random shuffle, 2 fixed 3,1,0,2
  //   kill_after: kill on its own cycle before beat k (0..3), -1 none
  //   kill_last : kill coincident with the final beat
  //   inv_after : snoop on its own cycle before beat k (0..3), 4 = with the final beat,
  //               5 = during the write cycle, -1 none
  task automatic fill(input logic [39:0] pa, input logic [1:0] way, input int ack_dly,
                      input int order_mode, input int kill_after, input bit kill_last,
                      input int inv_after, input logic [11:0] inv_pa, input bit fixed_data);
    logic [63:0] d[4];
    int ord[4];
    bit killed, poisoned, exp_we;
    for (int i = 0; i < 4; i++) begin
      d[i] = fixed_data ? 64'hA0 + 64'(i) : {$urandom(), $urandom()};
      ord[i] = i;
    end
    if (order_mode == 1) begin
      for (int i = 3; i > 0; i--) begin
        int j, t;
        j = $urandom_range(0, i);
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
    end else if (order_mode == 2) begin
      ord[0] = 3; ord[1] = 1; ord[2] = 0; ord[3] = 2;
    end
    killed   = (kill_after >= 0) || kill_last;
    poisoned = (inv_after >= 0) && (inv_after <= 4) && (inv_pa[11:5] == pa[11:5]);
    exp_we   = !killed && !poisoned;

    chk("ready_before_miss", miss_ready, 1'b1);
    miss_valid = 1; miss_paddr = pa; miss_way = way;
    step(1);
    miss_valid = 0; miss_paddr = {$urandom(), $urandom()}; miss_way = 2'($urandom());
    chk("req_valid", req_valid, 1'b1);
    chk("req_paddr", req_paddr, pa & ~40'h1F);
    chk("req_way", req_way, way);
    chk("busy_req", busy, 1'b1);
    for (int i = 0; i < ack_dly; i++) begin
      step(1);
      chk("req_hold", {req_valid, req_paddr}, {1'b1, pa & ~40'h1F});
    end
    ack = 1;
    step(1);
    ack = 0;
    for (int k = 0; k < 4; k++) begin
      if (kill_after == k) begin kill = 1; step(1); kill = 0; end
      if (inv_after == k) begin inv_valid = 1; inv_paddr = inv_pa; step(1); inv_valid = 0; end
      resp_valid = 1; resp_beat = 2'(ord[k]); resp_data = d[ord[k]];
      if (k == 3 && kill_last) kill = 1;
      if (k == 3 && inv_after == 4) begin inv_valid = 1; inv_paddr = inv_pa; end
      step(1);
      resp_valid = 0; kill = 0; inv_valid = 0;
    end
    chk("we_after_last", line_we, exp_we);
    chk("ready_after_last", miss_ready, killed);
    if (exp_we) begin
      exp_fills++; exp_writes++;
      chk("line_data", line_data, {d[3], d[2], d[1], d[0]});
      chk("line_idx", line_idx, pa[11:5]);
      chk("line_tag", line_tag, pa[39:12]);
      chk("line_way", line_way, way);
    end
    if (!killed) begin
      if (inv_after == 5) begin inv_valid = 1; inv_paddr = {pa[11:5], 5'h0}; end
      step(1);
      inv_valid = 0;
      chk("we_one_cycle", line_we, 1'b0);
      chk("ready_after_write", miss_ready, 1'b1);
    end
    chk("fill_cnt", fill_cnt, 16'(exp_fills));
  endtask

  initial begin
    logic [39:0]  pa;
    logic [127:0] wd[4];
    logic [63:0]  od;
    int           word[4];

    clear_inputs();
    rst = 1;
    step(2);
    rst = 0;
    chk_reset_state("reset");

    // basic fill: ack in cycle 3, beats A0..A3 in order
    fill(40'h80001234, 2'd2, 2, 0, -1, 0, -1, 12'h0, 1);
    chk("basic_tag_const", line_tag, 28'h0080001);
    chk("basic_idx_const", line_idx, 7'h11);
    chk("basic_cnt_const", fill_cnt, 16'd1);

    // out-of-order beats
    fill(40'h80001234, 2'd1, 0, 2, -1, 0, -1, 12'h0, 1);

    // kill in WAIT after two beats; remaining beats drained
    fill(40'h80001234, 2'd3, 1, 0, 2, 0, -1, 12'h0, 0);
    // kill together with the final beat
    fill(40'h12345678A0, 2'd0, 0, 1, -1, 1, -1, 12'h0, 0);

    // kill in REQ before ack
    miss_valid = 1; miss_paddr = 40'h80001234; miss_way = 2'd2;
    step(1);
    miss_valid = 0;
    chk("kreq_valid", req_valid, 1'b1);
    kill = 1;
    step(1);
    kill = 0;
    chk("kreq_dropped", req_valid, 1'b0);
    chk("kreq_ready", miss_ready, 1'b1);
    chk("kreq_busy", busy, 1'b0);

    // kill coincident with ack: drain all four beats
    miss_valid = 1; miss_paddr = 40'h80001234; miss_way = 2'd2;
    step(1);
    miss_valid = 0;
    kill = 1; ack = 1;
    step(1);
    kill = 0; ack = 0;
    chk("kack_reqv", req_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("kack_busy", busy, 1'b1);
      resp_valid = 1; resp_beat = 2'(k); resp_data = {$urandom(), $urandom()};
      step(1);
      resp_valid = 0;
    end
    chk("kack_we", line_we, 1'b0);
    chk("kack_ready", miss_ready, 1'b1);
    chk("kack_cnt", fill_cnt, 16'(exp_fills));

    // snooped invalidation: matching index suppresses, other index does not
    fill(40'h80001234, 2'd2, 1, 0, -1, 0, 2, 12'h220, 0);
    fill(40'h80001234, 2'd2, 1, 0, -1, 0, 2, 12'h240, 0);
    fill(40'h80001234, 2'd2, 0, 1, -1, 0, 4, 12'h23F, 0);
    fill(40'h80001234, 2'd2, 0, 1, -1, 0, 5, 12'h220, 0);

    // reset in WAIT, stray beats in IDLE, then a clean fill
    miss_valid = 1; miss_paddr = 40'h80001234; miss_way = 2'd2;
    step(1);
    miss_valid = 0; ack = 1;
    step(1);
    ack = 0;
    for (int k = 0; k < 2; k++) begin
      resp_valid = 1; resp_beat = 2'(k); resp_data = {$urandom(), $urandom()};
      step(1);
    end
    resp_valid = 0;
    rst = 1;
    step(1);
    rst = 0;
    exp_fills = 0;
    chk_reset_state("midrst");
    for (int k = 2; k < 4; k++) begin
      resp_valid = 1; resp_beat = 2'(k); resp_data = {$urandom(), $urandom()};
      step(1);
    end
    resp_valid = 0;
    chk("stray_busy", busy, 1'b0);
    chk("stray_we", line_we, 1'b0);
    chk("stray_data", line_data, 256'h0);
    fill({$urandom(), $urandom()}, 2'($urandom()), 1, 1, -1, 0, -1, 12'h0, 0);

    // randomized fills
    for (int it = 0; it < 40; it++) begin
      int r, ka, ia;
      bit kl;
      logic [11:0] ipa;
      pa = {$urandom(), $urandom()};
      r = $urandom_range(0, 9);
      ka = (r < 2) ? $urandom_range(0, 3) : -1;
      kl = (r == 2);
      r = $urandom_range(0, 9);
      ia = -1;
      ipa = {pa[11:5], 5'($urandom())};
      if (r < 3) ia = $urandom_range(0, 5);
      else if (r < 5) begin ia = $urandom_range(0, 4); ipa = {pa[11:5] + 7'd1, 5'h0}; end
      fill(pa, 2'($urandom()), $urandom_range(0, 3), 1, ka, kl, ia, ipa, 0);
      step($urandom_range(0, 2));
    end

    // 512/128 configuration, beats 2,0,3,1
    for (int i = 0; i < 4; i++) wd[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    word[0] = 2; word[1] = 0; word[2] = 3; word[3] = 1;
    pa = {$urandom(), $urandom()};
    w_miss_valid = 1; w_miss_paddr = pa; w_miss_way = 2'd3;
    step(1);
    w_miss_valid = 0;
    chk("wide_reqpa", w_req_paddr, pa & ~40'h1F);
    w_ack = 1;
    step(1);
    w_ack = 0;
    for (int k = 0; k < 4; k++) begin
      w_resp_valid = 1; w_resp_beat = 2'(word[k]); w_resp_data = wd[word[k]];
      step(1);
    end
    w_resp_valid = 0;
    chk("wide_we", w_line_we, 1'b1);
    chk("wide_data", w_line_data, {wd[3], wd[2], wd[1], wd[0]});
    chk("wide_tag", w_line_tag, pa[39:12]);
    step(1);
    chk("wide_ready", w_miss_ready, 1'b1);
    chk("wide_cnt", w_fill_cnt, 16'd1);

    // single-beat configuration: first beat completes the fill
    od = {$urandom(), $urandom()};
    pa = {$urandom(), $urandom()};
    o_miss_valid = 1; o_miss_paddr = pa; o_miss_way = 2'd1;
    step(1);
    o_miss_valid = 0; o_ack = 1;
    step(1);
    o_ack = 0; o_resp_valid = 1; o_resp_beat = 1'b0; o_resp_data = od;
    step(1);
    o_resp_valid = 0;
    chk("one_we", o_line_we, 1'b1);
    chk("one_data", o_line_data, od);
    chk("one_idx", o_line_idx, pa[11:5]);
    step(1);
    chk("one_cnt", o_fill_cnt, 16'd1);
    o_miss_valid = 1; o_miss_paddr = pa;
    step(1);
    o_miss_valid = 0; o_ack = 1;
    step(1);
    o_ack = 0; o_inv_valid = 1; o_inv_paddr = {pa[11:5], 5'h0};
    step(1);
    o_inv_valid = 0; o_resp_valid = 1; o_resp_data = ~od;
    step(1);
    o_resp_valid = 0;
    chk("one_poison_we", o_line_we, 1'b0);
    step(1);
    chk("one_poison_ready", o_miss_ready, 1'b1);
    chk("one_poison_cnt", o_fill_cnt, 16'd1);

    step(2);
    chk("we_total", we_seen, exp_writes);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
